// File: rtl/dmem_responder.sv
// Single-port data memory responder: clears itself after reset, then serves
// byte/half/word loads and stores with a registered one-cycle response.
module dmem_responder #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [1:0]          req_thread,
    input  logic [ADDR_LEN-1:0] dram_addr,
    input  logic [XLEN-1:0]     dram_data_out,
    output logic                rsp_valid,
    output logic [1:0]          rsp_thread,
    output logic [XLEN-1:0]     dram_data_in,
    output logic                rsp_fault
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t          state;
    logic [IW-1:0]   clear_ptr;
    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            misaligned;
    logic [IW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0]      lane_en;
    logic [XLEN-1:0] bit_mask;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_val;
    logic            unused_addr;

    always_comb begin
        idx         = dram_addr[IW+1:2];
        lane        = dram_addr[1:0];
        unused_addr = ^dram_addr;
        accept      = req_valid & ready;

        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase

        case (req_size)
            2'b00:   lane_en = 4'b0001 << lane;
            2'b01:   lane_en = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase

        bit_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_en[i]}};
        end

        // Replicate store data so the lane mask alone selects the target bytes
        case (req_size)
            2'b00:   wdata = {4{dram_data_out[7:0]}};
            2'b01:   wdata = {2{dram_data_out[15:0]}};
            default: wdata = dram_data_out;
        endcase

        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};

        case (req_size)
            2'b00:   load_val = req_unsigned ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                             : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = req_unsigned ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                             : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            clear_ptr    <= '0;
            ready        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_thread   <= '0;
            dram_data_in <= '0;
            rsp_fault    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == IW'(DEPTH - 1)) begin
                        state <= SERVE;
                        ready <= 1'b1;
                    end
                end
                default: ;
            endcase
            rsp_valid    <= accept;
            rsp_thread   <= accept ? req_thread : '0;
            rsp_fault    <= accept & misaligned;
            dram_data_in <= (accept && !req_we && !misaligned) ? load_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clear_ptr] <= '0;
            end else if (accept && req_we && !misaligned) begin
                mem[idx] <= (rd_word & ~bit_mask) | (wdata & bit_mask);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (DEPTH=16): directed steps then random traffic,
// compared against a byte-array memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [1:0]  req_thread;
    logic [31:0] dram_addr;
    logic [31:0] dram_data_out;
    logic        rsp_valid;
    logic [1:0]  rsp_thread;
    logic [31:0] dram_data_in;
    logic        rsp_fault;

    int checks = 0;
    int failures = 0;
    logic [7:0] mm [NBYTES];

    dmem_responder #(.XLEN(32), .ADDR_LEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_thread(req_thread),
        .dram_addr(dram_addr), .dram_data_out(dram_data_out),
        .rsp_valid(rsp_valid), .rsp_thread(rsp_thread),
        .dram_data_in(dram_data_in), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
    endtask

    // One serve-phase cycle: drive, advance one edge, check the response.
    task automatic do_req(input string tag, input bit v, input bit we, input logic [1:0] sz,
                          input bit uns, input logic [1:0] thr, input logic [31:0] addr,
                          input logic [31:0] data);
        logic [31:0] exp_d;
        bit          exp_f;
        int          base;
        int          n;
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_thread = thr; dram_addr = addr; dram_data_out = data;
        n     = 1 << sz;
        base  = int'(addr % NBYTES);
        exp_f = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        exp_d = 32'd0;
        if (v && !exp_f) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[(base + i) % NBYTES] = 8'((data >> (8 * i)));
            end else begin
                for (int i = 0; i < n; i++)
                    exp_d = exp_d | (32'(mm[(base + i) % NBYTES]) << (8 * i));
                if (!uns && n < 4 && exp_d[8*n-1])
                    exp_d = exp_d | ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        check({tag, "_thread"}, 32'(rsp_thread), v ? 32'(thr) : 32'd0);
        check({tag, "_data"}, dram_data_in, exp_d);
        check({tag, "_fault"}, 32'(rsp_fault), v ? 32'(exp_f) : 32'd0);
    endtask

    // Expect DEPTH cycles with ready low (requests ignored), then ready high.
    task automatic wait_clear(input string tag);
        for (int c = 0; c < DEPTH; c++) begin
            check({tag, "_ready_low"}, 32'(ready), 32'd0);
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
            dram_addr = 32'(4 * c); dram_data_out = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        check({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_thread = 2'd0; dram_addr = '0; dram_data_out = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_thread", 32'(rsp_thread), 32'd0);
        check("rst_data", dram_data_in, 32'd0);
        check("rst_fault", 32'(rsp_fault), 32'd0);

        rst = 1'b0;
        wait_clear("clear0");
        do_req("ld3c", 1, 0, 2'd2, 0, 2'd0, 32'h3C, 32'd0);

        do_req("st8", 1, 1, 2'd2, 0, 2'd2, 32'h8, 32'hDEAD_BEEF);
        do_req("ld8", 1, 0, 2'd2, 0, 2'd1, 32'h8, 32'd0);
        do_req("lbB_s", 1, 0, 2'd0, 0, 2'd3, 32'hB, 32'd0);
        do_req("lbB_u", 1, 0, 2'd0, 1, 2'd0, 32'hB, 32'd0);
        do_req("shA", 1, 1, 2'd1, 0, 2'd1, 32'hA, 32'h0000_1234);
        do_req("ld8b", 1, 0, 2'd2, 0, 2'd2, 32'h8, 32'd0);
        do_req("lh8_s", 1, 0, 2'd1, 0, 2'd2, 32'h8, 32'd0);
        do_req("idle", 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'd0);

        do_req("st4", 1, 1, 2'd2, 0, 2'd0, 32'h4, 32'hA5A5_A5A5);
        do_req("lw6", 1, 0, 2'd2, 0, 2'd1, 32'h6, 32'd0);
        do_req("sh5", 1, 1, 2'd1, 0, 2'd2, 32'h5, 32'h0000_FFFF);
        do_req("ld4", 1, 0, 2'd2, 0, 2'd3, 32'h4, 32'd0);
        do_req("ill", 1, 1, 2'd3, 0, 2'd1, 32'h4, 32'h1111_1111);
        do_req("ld4b", 1, 0, 2'd2, 0, 2'd0, 32'h4, 32'd0);

        do_req("st44", 1, 1, 2'd2, 0, 2'd1, 32'h44, 32'h55);
        do_req("ld4al", 1, 0, 2'd2, 0, 2'd2, 32'h4, 32'd0);

        // Reset arriving together with a request must suppress its response
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; dram_addr = 32'h4;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_data", dram_data_in, 32'd0);
        model_clear();
        wait_clear("clear1");
        do_req("ld4rst", 1, 0, 2'd2, 0, 2'd1, 32'h4, 32'd0);
        do_req("ld8rst", 1, 0, 2'd2, 0, 2'd1, 32'h8, 32'd0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_req("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, default 32, data width in bits; only 32 is supported.
REQ-002 Parameter ADDR_LEN, default 32, request address width.
REQ-003 Parameter DEPTH, default 1024, memory size in XLEN words; must be a power of two and at least 4.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port ready, output, 1, high when requests are accepted.
REQ-008 Port req_valid, input, 1, request present this cycle.
REQ-009 Port req_we, input, 1, 1 = store, 0 = load.
REQ-010 Port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 Port req_unsigned, input, 1, load zero-extends when 1 and sign-extends when 0.
REQ-012 Port req_thread, input, 2, issuing hardware thread id.
REQ-013 Port dram_addr, input, ADDR_LEN, byte address.
REQ-014 Port dram_data_out, input, XLEN, store data, right-aligned.
REQ-015 Port rsp_valid, output, 1, one-cycle response strobe.
REQ-016 Port rsp_thread, output, 2, req_thread echoed with the response.
REQ-017 Port dram_data_in, output, XLEN, load result; 0 for stores and faults.
REQ-018 Port rsp_fault, output, 1, misaligned or illegal request.

Function
REQ-019 The FSM SHALL have two states: CLEAR and SERVE.
- In CLEAR, one word is written each cycle, mem[clear_ptr] = 0, and clear_ptr increments.
- At clear_ptr == DEPTH-1 the FSM moves to SERVE on the next edge.
REQ-020 ready SHALL equal (state == SERVE), registered; it first goes high exactly DEPTH cycles after rst deasserts.
REQ-021 Requests with ready = 0 SHALL be ignored: no memory change and no response.
REQ-022 A request is accepted when req_valid & ready; throughput is one request per cycle with no back-pressure.
REQ-023 Word index = dram_addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses alias and wrap modulo 4*DEPTH bytes.
REQ-024 Misalignment detection:
- A half access with addr[0] = 1 is misaligned.
- A word access with addr[1:0] != 0 is misaligned.
- req_size = 11 is illegal.
- Any of these: no write, and the response carries rsp_fault = 1 with dram_data_in = 0.
REQ-025 Store write lanes:
- byte: dram_data_out[7:0] to lane addr[1:0].
- half: dram_data_out[15:0] to lanes {addr[1],0} and {addr[1],1}.
- word: all four lanes.
- Other lanes are unchanged.
REQ-026 Load result is the selected lane(s) shifted to bit 0, then sign- or zero-extended per req_unsigned; word loads ignore req_unsigned.
REQ-027 Response timing for every accepted request:
- rsp_valid = 1 exactly one cycle after acceptance.
- rsp_thread, dram_data_in and rsp_fault are valid in that same cycle.
- All three are held at 0 when rsp_valid = 0.
REQ-028 A load accepted the cycle after a store to the same word SHALL return the post-store data; no hazard stall is required.
REQ-029 Consecutive accepted requests SHALL produce consecutive rsp_valid pulses in issue order.

Reset
REQ-030 While rst = 1, the block SHALL hold:
- state = CLEAR, clear_ptr = 0;
- ready = 0, rsp_valid = 0, rsp_thread = 0, dram_data_in = 0, rsp_fault = 0.
REQ-031 rst asserted mid-operation (during CLEAR or SERVE) SHALL drop any pending response on the next edge and restart the full clear; memory reads as all zeros afterward.

Verification (DEPTH = 16)
REQ-032 Release rst at cycle 0 -> ready = 0 for cycles 0..15 and 1 from cycle 16; a load of addr 0x3C then returns 0x00000000.
REQ-033 Store word 0xDEADBEEF to 0x8 (thread 2), then load word 0x8 next cycle (thread 1) -> two consecutive rsp_valid pulses:
- store response: data 0, rsp_thread 2;
- load response: data 0xDEADBEEF, rsp_thread 1.
REQ-034 After REQ-033, byte loads of 0xB:
- signed -> 0xFFFFFFDE;
- unsigned -> 0x000000DE.
REQ-035 After REQ-033, store half 0x1234 to 0xA, then load word 0x8 -> 0x1234BEEF.
REQ-036 Misaligned and illegal requests:
- load word 0x6 -> rsp_fault = 1, data 0;
- store half to 0x5 -> rsp_fault = 1, word 0x4 unchanged;
- req_size = 11 -> rsp_fault = 1.
REQ-037 Aliasing and reset mid-operation:
- store word 0x55 to 0x44 -> load of 0x4 returns 0x55;
- assert rst one cycle -> ready is low for 16 cycles, then load 0x4 returns 0.
